// File: rtl/zx_ps2_matrix.sv
// PS/2 set-2 scan codes to ZX Spectrum keyboard matrix, read through port #FE. Updates one cycle after the strobe; ps2_data_clk has no backpressure.
// Optional ZX_PS2_KEMPSTON_EN adds a Kempston joystick output driven by the arrow keys and keypad 0.
module zx_ps2_matrix #(
    parameter int ROWS    = 8,
    parameter int COLS    = 5,
    parameter int CNT_W   = 2,
    parameter int TIMEOUT = 500000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        ps2_data_clk,
    input  logic [7:0]  ps2_data,
    input  logic [15:0] A,
    output logic [7:0]  D
`ifdef ZX_PS2_KEMPSTON_EN
    ,
    output logic [4:0]  kempston
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK, S_SKIP} state_t;

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    // A cell is {valid, row[2:0], col[2:0]}.
    localparam logic [6:0] NONE = 7'b0_000_000;
    localparam logic [6:0] CS   = 7'b1_000_000;
    localparam logic [6:0] SS   = 7'b1_111_001;

    function automatic logic [6:0] f_cell(input int r, input int c);
        return {1'b1, 3'(r), 3'(c)};
    endfunction

    function automatic logic [13:0] f_map(input logic [7:0] code, input logic ext);
        f_map = {NONE, NONE};
        if (ext) begin
            case (code)
                8'h75: f_map = {CS, f_cell(4, 3)};
                8'h6B: f_map = {CS, f_cell(3, 4)};
                8'h72: f_map = {CS, f_cell(4, 4)};
                8'h74: f_map = {CS, f_cell(4, 2)};
                8'h5A: f_map = {NONE, f_cell(6, 0)};
                8'h71: f_map = {CS, f_cell(4, 0)};
                8'h14: f_map = {NONE, SS};
                default: f_map = {NONE, NONE};
            endcase
        end else begin
            case (code)
                8'h12: f_map = {NONE, CS};          8'h1A: f_map = {NONE, f_cell(0, 1)};
                8'h22: f_map = {NONE, f_cell(0, 2)}; 8'h21: f_map = {NONE, f_cell(0, 3)};
                8'h2A: f_map = {NONE, f_cell(0, 4)}; 8'h1C: f_map = {NONE, f_cell(1, 0)};
                8'h1B: f_map = {NONE, f_cell(1, 1)}; 8'h23: f_map = {NONE, f_cell(1, 2)};
                8'h2B: f_map = {NONE, f_cell(1, 3)}; 8'h34: f_map = {NONE, f_cell(1, 4)};
                8'h15: f_map = {NONE, f_cell(2, 0)}; 8'h1D: f_map = {NONE, f_cell(2, 1)};
                8'h24: f_map = {NONE, f_cell(2, 2)}; 8'h2D: f_map = {NONE, f_cell(2, 3)};
                8'h2C: f_map = {NONE, f_cell(2, 4)}; 8'h16: f_map = {NONE, f_cell(3, 0)};
                8'h1E: f_map = {NONE, f_cell(3, 1)}; 8'h26: f_map = {NONE, f_cell(3, 2)};
                8'h25: f_map = {NONE, f_cell(3, 3)}; 8'h2E: f_map = {NONE, f_cell(3, 4)};
                8'h45: f_map = {NONE, f_cell(4, 0)}; 8'h46: f_map = {NONE, f_cell(4, 1)};
                8'h3E: f_map = {NONE, f_cell(4, 2)}; 8'h3D: f_map = {NONE, f_cell(4, 3)};
                8'h36: f_map = {NONE, f_cell(4, 4)}; 8'h4D: f_map = {NONE, f_cell(5, 0)};
                8'h44: f_map = {NONE, f_cell(5, 1)}; 8'h43: f_map = {NONE, f_cell(5, 2)};
                8'h3C: f_map = {NONE, f_cell(5, 3)}; 8'h35: f_map = {NONE, f_cell(5, 4)};
                8'h5A: f_map = {NONE, f_cell(6, 0)}; 8'h4B: f_map = {NONE, f_cell(6, 1)};
                8'h42: f_map = {NONE, f_cell(6, 2)}; 8'h3B: f_map = {NONE, f_cell(6, 3)};
                8'h33: f_map = {NONE, f_cell(6, 4)}; 8'h29: f_map = {NONE, f_cell(7, 0)};
                8'h59: f_map = {NONE, SS};          8'h3A: f_map = {NONE, f_cell(7, 2)};
                8'h31: f_map = {NONE, f_cell(7, 3)}; 8'h32: f_map = {NONE, f_cell(7, 4)};
                8'h41: f_map = {SS, f_cell(7, 3)};  8'h49: f_map = {SS, f_cell(7, 2)};
                8'h4A: f_map = {SS, f_cell(0, 4)};  8'h4C: f_map = {SS, f_cell(5, 1)};
                8'h55: f_map = {SS, f_cell(6, 1)};  8'h4E: f_map = {SS, f_cell(6, 3)};
                8'h0E: f_map = {SS, f_cell(4, 3)};  8'h58: f_map = {CS, SS};
                8'h0D: f_map = {CS, f_cell(3, 0)};  8'h66: f_map = {CS, f_cell(4, 0)};
                8'h75: f_map = {CS, f_cell(4, 3)};  8'h6B: f_map = {CS, f_cell(3, 4)};
                8'h72: f_map = {CS, f_cell(4, 4)};  8'h74: f_map = {CS, f_cell(4, 2)};
                default: f_map = {NONE, NONE};
            endcase
        end
    endfunction

    state_t               r_state;
    logic [2:0]           r_skip;
    logic [TO_W-1:0]      r_to_cnt;
    logic [CNT_W-1:0]     r_cnt [ROWS][COLS];

    logic                 w_make, w_brk, w_clear, w_ext;
    logic [13:0]          w_map;
    logic                 w_hit [ROWS][COLS];
    logic                 w_unused;

    assign w_unused = ^A;
    assign w_ext    = (r_state == S_EXT) || (r_state == S_EXTBRK);
    assign w_map    = f_map(ps2_data, w_ext);

    always_comb begin
        w_make  = 1'b0;
        w_brk   = 1'b0;
        w_clear = 1'b0;
        if (ps2_data_clk) begin
            case (r_state)
                S_IDLE: begin
                    case (ps2_data)
                        8'hF0, 8'hE0, 8'hE1, 8'hFA, 8'hAA, 8'hEE: w_make = 1'b0;
                        8'h00, 8'hFF: w_clear = 1'b1;
                        default: w_make = 1'b1;
                    endcase
                end
                S_BRK, S_EXTBRK: w_brk = 1'b1;
                S_EXT: w_make = (ps2_data != 8'hF0);
                default: w_make = 1'b0;
            endcase
        end
    end

    // Cells outside ROWS x COLS never match, so such mappings fall away here.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_hit[r][c] = (w_map[6] && w_map[5:3] == 3'(r) && w_map[2:0] == 3'(c)) ||
                              (w_map[13] && w_map[12:10] == 3'(r) && w_map[9:7] == 3'(c));
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_skip   <= 3'd0;
            r_to_cnt <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_cnt[r][c] <= '0;
        end else begin
            if (ps2_data_clk) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        case (ps2_data)
                            8'hF0: r_state <= S_BRK;
                            8'hE0: r_state <= S_EXT;
                            8'hE1: begin
                                r_state <= S_SKIP;
                                r_skip  <= 3'd7;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                    S_EXT: r_state <= (ps2_data == 8'hF0) ? S_EXTBRK : S_IDLE;
                    S_SKIP: begin
                        r_skip <= r_skip - 3'd1;
                        if (r_skip <= 3'd1)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TO_W'(TIMEOUT - 1)) begin
                    r_state  <= S_IDLE;
                    r_skip   <= 3'd0;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (w_clear)
                        r_cnt[r][c] <= '0;
                    else if (w_hit[r][c] && w_make && r_cnt[r][c] != CMAX)
                        r_cnt[r][c] <= r_cnt[r][c] + 1'b1;
                    else if (w_hit[r][c] && w_brk && r_cnt[r][c] != '0)
                        r_cnt[r][c] <= r_cnt[r][c] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        D = 8'hFF;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!A[8+r] && r_cnt[r][c] != '0)
                    D[c] = 1'b0;
    end

`ifdef ZX_PS2_KEMPSTON_EN
    // Bit order {fire, up, down, left, right}.
    function automatic logic [4:0] f_kemp(input logic [7:0] code, input logic ext);
        case (code)
            8'h75:   f_kemp = 5'b01000;
            8'h72:   f_kemp = 5'b00100;
            8'h6B:   f_kemp = 5'b00010;
            8'h74:   f_kemp = 5'b00001;
            8'h70:   f_kemp = ext ? 5'b00000 : 5'b10000;
            default: f_kemp = 5'b00000;
        endcase
    endfunction

    logic [CNT_W-1:0] r_kcnt [5];
    logic [4:0]       w_kmask;

    assign w_kmask = f_kemp(ps2_data, w_ext);

    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < 5; i++) begin
            if (reset || w_clear)
                r_kcnt[i] <= '0;
            else if (w_kmask[i] && w_make && r_kcnt[i] != CMAX)
                r_kcnt[i] <= r_kcnt[i] + 1'b1;
            else if (w_kmask[i] && w_brk && r_kcnt[i] != '0)
                r_kcnt[i] <= r_kcnt[i] - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++)
            kempston[i] = (r_kcnt[i] != '0);
    end
`endif

endmodule

// File: tb/tb_zx_ps2_matrix.sv
// Bench for zx_ps2_matrix: table-driven key model checked every cycle, plus hand-computed spot values.
module tb_zx_ps2_matrix;
    localparam int TO  = 16;
    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stb = 1'b0;
    logic [7:0]  dat = 8'h00;
    logic [15:0] A = 16'hFFFF;
    logic [7:0]  D;
`ifdef ZX_PS2_KEMPSTON_EN
    logic [4:0]  kempston;
`endif

    zx_ps2_matrix #(.ROWS(8), .COLS(5), .CNT_W(2), .TIMEOUT(TO)) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .ps2_data_clk (stb),
        .ps2_data     (dat),
        .A            (A),
        .D            (D)
`ifdef ZX_PS2_KEMPSTON_EN
        ,
        .kempston     (kempston)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model state: key press counts and pending prefix bytes.
    int mcnt [8][5];
    int mk [5];
    bit p_brk, p_ext;
    int p_skip;
    int gap;
    int mapr [2][256][2];
    int mapc [2][256][2];
    int kmap [2][256];

    int rowcodes [8][5] = '{
        '{'h12, 'h1A, 'h22, 'h21, 'h2A}, '{'h1C, 'h1B, 'h23, 'h2B, 'h34},
        '{'h15, 'h1D, 'h24, 'h2D, 'h2C}, '{'h16, 'h1E, 'h26, 'h25, 'h2E},
        '{'h45, 'h46, 'h3E, 'h3D, 'h36}, '{'h4D, 'h44, 'h43, 'h3C, 'h35},
        '{'h5A, 'h4B, 'h42, 'h3B, 'h33}, '{'h29, 'h59, 'h3A, 'h31, 'h32}};

    task automatic add(input int e, input int code, input int r0, input int c0,
                       input int r1, input int c1);
        mapr[e][code][0] = r0; mapc[e][code][0] = c0;
        mapr[e][code][1] = r1; mapc[e][code][1] = c1;
    endtask

    task automatic init_maps();
        for (int e = 0; e < 2; e++)
            for (int k = 0; k < 256; k++) begin
                add(e, k, -1, -1, -1, -1);
                kmap[e][k] = 0;
            end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                add(0, rowcodes[r][c], r, c, -1, -1);
        add(0, 'h41, 7, 1, 7, 3); add(0, 'h49, 7, 1, 7, 2); add(0, 'h4A, 7, 1, 0, 4);
        add(0, 'h4C, 7, 1, 5, 1); add(0, 'h55, 7, 1, 6, 1); add(0, 'h4E, 7, 1, 6, 3);
        add(0, 'h0E, 7, 1, 4, 3); add(0, 'h58, 0, 0, 7, 1); add(0, 'h0D, 0, 0, 3, 0);
        add(0, 'h66, 0, 0, 4, 0);
        for (int e = 0; e < 2; e++) begin
            add(e, 'h75, 0, 0, 4, 3); add(e, 'h6B, 0, 0, 3, 4);
            add(e, 'h72, 0, 0, 4, 4); add(e, 'h74, 0, 0, 4, 2);
            kmap[e]['h75] = 8; kmap[e]['h72] = 4; kmap[e]['h6B] = 2; kmap[e]['h74] = 1;
        end
        kmap[0]['h70] = 16;
        add(1, 'h5A, 6, 0, -1, -1); add(1, 'h71, 0, 0, 4, 0); add(1, 'h14, 7, 1, -1, -1);
    endtask

    function automatic int clampc(input int v);
        return (v < 0) ? 0 : ((v > MAXC) ? MAXC : v);
    endfunction

    task automatic clear_keys();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                mcnt[r][c] = 0;
        for (int i = 0; i < 5; i++) mk[i] = 0;
    endtask

    task automatic apply(input int e, input int code, input int d);
        for (int k = 0; k < 2; k++)
            if (mapr[e][code][k] >= 0)
                mcnt[mapr[e][code][k]][mapc[e][code][k]] =
                    clampc(mcnt[mapr[e][code][k]][mapc[e][code][k]] + d);
        for (int i = 0; i < 5; i++)
            if (kmap[e][code][i])
                mk[i] = clampc(mk[i] + d);
    endtask

    task automatic model_byte(input int b);
        if (p_skip > 0) begin
            p_skip--;
        end else if (!p_brk && b == 'hF0) begin
            p_brk = 1'b1;
        end else if (!p_brk && !p_ext && b == 'hE0) begin
            p_ext = 1'b1;
        end else if (!p_brk && !p_ext && b == 'hE1) begin
            p_skip = 7;
        end else if (!p_brk && !p_ext && (b == 'hFA || b == 'hAA || b == 'hEE)) begin
            p_skip = 0;
        end else if (!p_brk && !p_ext && (b == 'h00 || b == 'hFF)) begin
            clear_keys();
        end else begin
            apply(p_ext ? 1 : 0, b, p_brk ? -1 : 1);
            p_brk = 1'b0;
            p_ext = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            clear_keys();
            p_brk = 1'b0; p_ext = 1'b0; p_skip = 0; gap = 0;
        end else if (stb) begin
            if ((p_brk || p_ext || p_skip > 0) && gap >= TO) begin
                p_brk = 1'b0; p_ext = 1'b0; p_skip = 0;
            end
            model_byte(int'(dat));
            gap = 0;
        end else begin
            gap++;
        end
    end

    function automatic logic [7:0] exp_d(input logic [15:0] a);
        logic [7:0] v;
        v = 8'hFF;
        for (int r = 0; r < 8; r++)
            if (!a[8+r])
                for (int c = 0; c < 5; c++)
                    if (mcnt[r][c] > 0) v[c] = 1'b0;
        return v;
    endfunction

    function automatic logic [4:0] exp_k();
        logic [4:0] v;
        for (int i = 0; i < 5; i++) v[i] = (mk[i] > 0);
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (D !== exp_d(A)) begin
                n_bad++;
                $display("FAIL cycle_D t=%0t A=%h: got %h, required %h", $time, A, D, exp_d(A));
            end
`ifdef ZX_PS2_KEMPSTON_EN
            n_cmp++;
            if (kempston !== exp_k()) begin
                n_bad++;
                $display("FAIL cycle_kemp t=%0t: got %b, required %b", $time, kempston, exp_k());
            end
`endif
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #2;
        stb = 1'b1; dat = b;
        @(posedge clk); #2;
        stb = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [15:0] a, input logic [7:0] exp);
        A = a;
        #1;
        n_cmp++;
        if (D !== exp) begin
            n_bad++;
            $display("FAIL %s: D=%h required %h", nm, D, exp);
        end
    endtask

    initial begin
        init_maps();
        @(posedge clk); #2;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        lit("reset_row0", 16'hFEFE, 8'hFF);
        lit("reset_all", 16'h00FE, 8'hFF);
        send(8'h1A);
        lit("make_Z", 16'hFEFE, 8'hFD);
        send(8'hF0); send(8'h1A);
        lit("break_Z", 16'hFEFE, 8'hFF);

        send(8'h12); send(8'hE0); send(8'h75);
        lit("cs_shared", 16'hFEFE, 8'hFE);
        lit("rows_0_4", 16'hEEFE, 8'hF6);
        send(8'hE0); send(8'hF0); send(8'h75);
        lit("cs_still_held", 16'hFEFE, 8'hFE);
        lit("seven_released", 16'hEFFE, 8'hFF);
        send(8'hF0); send(8'h12);
        lit("cs_released", 16'hFEFE, 8'hFF);

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        lit("pause_then_A", 16'hFDFE, 8'hFE);
        lit("pause_all_rows", 16'h00FE, 8'hFE);
        send(8'hF0); send(8'h1C);

        // Gap of TO-1 idle cycles keeps the E0 prefix; a gap of TO drops it.
        send(8'hE0);
        repeat (TO - 2) @(posedge clk);
        send(8'h1A);
        lit("no_timeout", 16'hFEFE, 8'hFF);
        send(8'hE0);
        repeat (TO - 1) @(posedge clk);
        send(8'h1A);
        lit("timeout_base", 16'hFEFE, 8'hFD);
        send(8'hF0); send(8'h1A);

        send(8'h15); send(8'h4D);
        lit("q_and_p", 16'h5A5A, 8'hFE);
        send(8'h00);
        lit("overrun_clear", 16'h5A5A, 8'hFF);

        repeat (5) send(8'h12);
        send(8'hF0); send(8'h12); send(8'hF0); send(8'h12);
        lit("sat_two_breaks", 16'hFEFE, 8'hFE);
        send(8'hF0); send(8'h12);
        lit("sat_released", 16'hFEFE, 8'hFF);

        send(8'h58);
        lit("cs_ss_combo", 16'h7EFE, 8'hFC);
        send(8'hF0); send(8'h58);
        send(8'hFA); send(8'hAA); send(8'hEE); send(8'h07);
        send(8'hE0); send(8'h12);
        lit("fake_shift", 16'h00FE, 8'hFF);
        send(8'hE0); send(8'h14);
        lit("ext_ss", 16'h7FFE, 8'hFD);
        send(8'hFF);

        send(8'hF0);
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        send(8'h1A);
        lit("reset_mid_seq", 16'hFEFE, 8'hFD);
        @(posedge clk); #2;
        reset = 1'b1; stb = 1'b1; dat = 8'h22;
        @(posedge clk); #2;
        reset = 1'b0; stb = 1'b0;
        lit("strobe_in_reset", 16'hFEFE, 8'hFF);

`ifdef ZX_PS2_KEMPSTON_EN
        send(8'hE0); send(8'h6B);
        #1; n_cmp++;
        if (kempston !== 5'b00010) begin
            n_bad++; $display("FAIL kemp_left: got %b required %b", kempston, 5'b00010);
        end
        lit("kemp_left_matrix", 16'hF7FE, 8'hEF);
        send(8'h70);
        #1; n_cmp++;
        if (kempston !== 5'b10010) begin
            n_bad++; $display("FAIL kemp_fire: got %b required %b", kempston, 5'b10010);
        end
        send(8'h00);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      b = 8'hF0;
            else if (sel == 1) b = 8'hE0;
            else if (sel == 2 && $urandom_range(0, 3) == 0) b = 8'hE1;
            else if (sel == 3) b = 8'(rowcodes[$urandom_range(0, 7)][$urandom_range(0, 4)]);
            else               b = 8'($urandom_range(0, 255));
            A = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 15) == 0)
                repeat ($urandom_range(TO - 3, TO + 2)) @(posedge clk);
            send(b);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
